uart_prog_loader: RTL and testbench

UART_PROG_LOADER -- requirements
Module: uart_prog_loader

---
 rtl/uart_prog_loader.sv | 243 ++++++++++++++++++++++++
 tb/tb_uart_prog_loader.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: packet-based program loader sitting behind a UART.
// Packet: SOP, CMD, LEN_HI, LEN_LO, LEN payload bytes, CHK, EOP.
//   CMD_WR streams the payload into program memory as little-endian 32-bit words
//   while holding the SoC CPU in reset; CMD_RD reports the word count of the last write.
//   The response is ACK or NAK, plus the count byte for a good CMD_RD.
// Ports:
//   clk, resetn                     - clock, asynchronous active-low reset
//   rx_valid, rx_data               - received byte strobe and data
//   tx_valid, tx_data, tx_ready     - response byte handshake
//   progmem_wen/_waddr/_wdata       - one-cycle program-memory write (word index, data)
//   soc_hold                        - CPU held in reset while a load is in progress
//   busy                            - state machine is not idle
module uart_prog_loader #(
  parameter logic [7:0]  SOP         = 8'h23,
  parameter logic [7:0]  EOP         = 8'h0d,
  parameter logic [7:0]  CMD_WR      = 8'h07,
  parameter logic [7:0]  CMD_RD      = 8'h08,
  parameter int unsigned TIMEOUT_CYC = 25000000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        progmem_wen,
  output logic [31:0] progmem_waddr,
  output logic [31:0] progmem_wdata,
  output logic        soc_hold,
  output logic        busy
);

  localparam int unsigned TW  = 32;
  localparam logic [7:0]  ACK = 8'h06;
  localparam logic [7:0]  NAK = 8'h15;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_LENH, S_LENL, S_DATA, S_CHK, S_EOP, S_RESP1, S_RESP2
  } state_t;

  state_t        state;
  logic [7:0]    sum;        // running checksum of CMD, LEN and payload
  logic [7:0]    len_hi;
  logic [15:0]   remain;     // payload bytes still expected
  logic          is_wr;      // current packet is a write
  logic          resp_ack;   // RESP1 byte is an ACK
  logic          chk_ok;     // CHK byte matched the running sum
  logic [31:0]   word_addr;  // next word index to write
  logic [15:0]   wcount;     // words written by the last write packet
  logic [31:0]   wbuf;       // word being assembled, unfilled lanes stay zero
  logic [1:0]    bidx;       // byte lane of the next payload byte
  logic [TW-1:0] timer;      // cycles since the last accepted byte
  logic          in_pkt;

  assign in_pkt = (state == S_CMD) || (state == S_LENH) || (state == S_LENL) ||
                  (state == S_DATA) || (state == S_CHK) || (state == S_EOP);

  // Packet state machine with registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      sum           <= 8'h00;
      len_hi        <= 8'h00;
      remain        <= 16'h0000;
      is_wr         <= 1'b0;
      resp_ack      <= 1'b0;
      chk_ok        <= 1'b0;
      word_addr     <= 32'h0;
      wcount        <= 16'h0000;
      wbuf          <= 32'h0;
      bidx          <= 2'd0;
      timer         <= '0;
      tx_valid      <= 1'b0;
      tx_data       <= 8'h00;
      progmem_wen   <= 1'b0;
      progmem_waddr <= 32'h0;
      progmem_wdata <= 32'h0;
      soc_hold      <= 1'b0;
      busy          <= 1'b0;
    end else begin
      progmem_wen <= 1'b0;

      case (state)
        S_IDLE: begin
          if (rx_valid && rx_data == SOP) begin
            state <= S_CMD;
            sum   <= 8'h00;
            busy  <= 1'b1;
          end
        end

        S_CMD: begin
          if (rx_valid) begin
            sum <= sum + rx_data;
            if (rx_data == CMD_WR) begin
              is_wr     <= 1'b1;
              word_addr <= 32'h0;
              wcount    <= 16'h0000;
              wbuf      <= 32'h0;
              bidx      <= 2'd0;
              soc_hold  <= 1'b1;
              state     <= S_LENH;
            end else if (rx_data == CMD_RD) begin
              is_wr <= 1'b0;
              state <= S_LENH;
            end else begin
              is_wr    <= 1'b0;
              state    <= S_RESP1;
              tx_valid <= 1'b1;
              tx_data  <= NAK;
              resp_ack <= 1'b0;
            end
          end
        end

        S_LENH: begin
          if (rx_valid) begin
            sum    <= sum + rx_data;
            len_hi <= rx_data;
            state  <= S_LENL;
          end
        end

        S_LENL: begin
          if (rx_valid) begin
            sum <= sum + rx_data;
            // A read carries no payload; any length is rejected without consuming bytes
            if (!is_wr && {len_hi, rx_data} != 16'h0000) begin
              state    <= S_RESP1;
              tx_valid <= 1'b1;
              tx_data  <= NAK;
              resp_ack <= 1'b0;
            end else if ({len_hi, rx_data} == 16'h0000) begin
              state <= S_CHK;
            end else begin
              remain <= {len_hi, rx_data};
              state  <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (rx_valid) begin
            sum    <= sum + rx_data;
            remain <= remain - 16'd1;
            bidx   <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              progmem_wen   <= 1'b1;
              progmem_waddr <= word_addr;
              progmem_wdata <= {rx_data, wbuf[23:0]};
              word_addr     <= word_addr + 32'd1;
              wcount        <= wcount + 16'd1;
              wbuf          <= 32'h0;
            end else begin
              wbuf[{bidx, 3'b000} +: 8] <= rx_data;
            end
            if (remain == 16'd1) state <= S_CHK;
          end
        end

        S_CHK: begin
          if (rx_valid) begin
            chk_ok <= (rx_data == sum);
            // Flush a partially filled final word
            if (is_wr && bidx != 2'd0) begin
              progmem_wen   <= 1'b1;
              progmem_waddr <= word_addr;
              progmem_wdata <= wbuf;
              word_addr     <= word_addr + 32'd1;
              wcount        <= wcount + 16'd1;
              wbuf          <= 32'h0;
              bidx          <= 2'd0;
            end
            state <= S_EOP;
          end
        end

        S_EOP: begin
          if (rx_valid) begin
            state    <= S_RESP1;
            tx_valid <= 1'b1;
            if (chk_ok && rx_data == EOP) begin
              tx_data  <= ACK;
              resp_ack <= 1'b1;
            end else begin
              tx_data  <= NAK;
              resp_ack <= 1'b0;
            end
          end
        end

        S_RESP1: begin
          if (tx_ready) begin
            soc_hold <= 1'b0;
            if (resp_ack && !is_wr) begin
              tx_data <= wcount[7:0];
              state   <= S_RESP2;
            end else begin
              tx_valid <= 1'b0;
              tx_data  <= 8'h00;
              state    <= S_IDLE;
              busy     <= 1'b0;
            end
          end
        end

        S_RESP2: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            state    <= S_IDLE;
            busy     <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Inter-byte timeout; only reachable when no byte arrived this cycle
      if (in_pkt) begin
        if (rx_valid) begin
          timer <= '0;
        end else if (timer == TIMER_LAST) begin
          timer    <= '0;
          state    <= S_RESP1;
          tx_valid <= 1'b1;
          tx_data  <= NAK;
          resp_ack <= 1'b0;
        end else begin
          timer <= timer + TW'(1);
        end
      end else begin
        timer <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: a table of packets with expected writes and
// responses, plus hand sequences for hold/stall, timeout and mid-packet reset.
module tb_uart_prog_loader;

  localparam int unsigned TO = 40;

  logic        clk = 1'b0;
  logic        resetn;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        progmem_wen;
  logic [31:0] progmem_waddr;
  logic [31:0] progmem_wdata;
  logic        soc_hold;
  logic        busy;

  uart_prog_loader #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .resetn(resetn),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .progmem_wen(progmem_wen), .progmem_waddr(progmem_waddr), .progmem_wdata(progmem_wdata),
    .soc_hold(soc_hold), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] wq [$];

  // Capture every write pulse as {addr, data}
  always @(posedge clk) begin
    if (progmem_wen) wq.push_back({progmem_waddr, progmem_wdata});
  end

  typedef struct {
    string        name;
    int           nb;
    logic [127:0] b;   // bytes, right-aligned, first byte most significant
    int           nw;
    logic [63:0]  w0;
    logic [63:0]  w1;
    int           nt;
    logic [15:0]  t;   // response bytes, right-aligned
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_bytes(input int v, input int count);
    for (int i = 0; i < count; i++) send_byte(vecs[v].b[8*(vecs[v].nb-1-i) +: 8]);
  endtask

  task automatic expect_tx(input logic [7:0] exp, input string nm);
    int n = 0;
    while (tx_valid !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check({nm, " tx_valid"}, 64'(tx_valid), 64'(1));
    check({nm, " tx_data"}, 64'(tx_data), 64'(exp));
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
  endtask

  task automatic run_vec(input int v);
    wq.delete();
    send_bytes(v, vecs[v].nb);
    for (int i = 0; i < vecs[v].nt; i++)
      expect_tx(vecs[v].t[8*(vecs[v].nt-1-i) +: 8], vecs[v].name);
    @(posedge clk); #1;
    check({vecs[v].name, " nwrites"}, 64'(wq.size()), 64'(vecs[v].nw));
    if (vecs[v].nw > 0 && wq.size() > 0) check({vecs[v].name, " write0"}, wq[0], vecs[v].w0);
    if (vecs[v].nw > 1 && wq.size() > 1) check({vecs[v].name, " write1"}, wq[1], vecs[v].w1);
    check({vecs[v].name, " idle busy"}, 64'(busy), 64'(0));
    check({vecs[v].name, " idle soc_hold"}, 64'(soc_hold), 64'(0));
  endtask

  initial begin
    int bad;
    vecs[0]  = '{"wr8_good", 14,
                 128'({8'h23,8'h07,8'h00,8'h08,8'h11,8'h22,8'h33,8'h44,8'h55,8'h66,8'h77,8'h88,8'h73,8'h0d}),
                 2, {32'd0, 32'h44332211}, {32'd1, 32'h88776655}, 1, 16'h0006};
    vecs[1]  = '{"wr5_partial", 11,
                 128'({8'h23,8'h07,8'h00,8'h05,8'h01,8'h02,8'h03,8'h04,8'h05,8'h1b,8'h0d}),
                 2, {32'd0, 32'h04030201}, {32'd1, 32'h00000005}, 1, 16'h0006};
    vecs[2]  = '{"rd_after_wr5", 6, 128'({8'h23,8'h08,8'h00,8'h00,8'h08,8'h0d}),
                 0, 64'h0, 64'h0, 2, 16'h0602};
    vecs[3]  = '{"wr8_badchk", 14,
                 128'({8'h23,8'h07,8'h00,8'h08,8'h11,8'h22,8'h33,8'h44,8'h55,8'h66,8'h77,8'h88,8'h74,8'h0d}),
                 2, {32'd0, 32'h44332211}, {32'd1, 32'h88776655}, 1, 16'h0015};
    vecs[4]  = '{"bad_cmd", 2, 128'({8'h23,8'h09}), 0, 64'h0, 64'h0, 1, 16'h0015};
    vecs[5]  = '{"rd_len1", 4, 128'({8'h23,8'h08,8'h00,8'h01}), 0, 64'h0, 64'h0, 1, 16'h0015};
    vecs[6]  = '{"rd_after_badchk", 6, 128'({8'h23,8'h08,8'h00,8'h00,8'h08,8'h0d}),
                 0, 64'h0, 64'h0, 2, 16'h0602};
    vecs[7]  = '{"wr0_bad_eop", 6, 128'({8'h23,8'h07,8'h00,8'h00,8'h07,8'h0e}),
                 0, 64'h0, 64'h0, 1, 16'h0015};
    vecs[8]  = '{"rd_after_wr0", 6, 128'({8'h23,8'h08,8'h00,8'h00,8'h08,8'h0d}),
                 0, 64'h0, 64'h0, 2, 16'h0600};
    vecs[9]  = '{"noise_wr1", 8, 128'({8'h55,8'h23,8'h07,8'h00,8'h01,8'hab,8'hb3,8'h0d}),
                 1, {32'd0, 32'h000000ab}, 64'h0, 1, 16'h0006};
    vecs[10] = '{"rd_after_wr1", 6, 128'({8'h23,8'h08,8'h00,8'h00,8'h08,8'h0d}),
                 0, 64'h0, 64'h0, 2, 16'h0601};

    resetn = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", {tx_valid, tx_data, progmem_wen, soc_hold, busy},
          {1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    check("reset waddr/wdata", {progmem_waddr, progmem_wdata}, 64'h0);
    resetn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post-reset idle", {tx_valid, busy, soc_hold}, 3'b000);

    for (int v = 0; v < 11; v++) run_vec(v);

    // soc_hold window and 100-cycle tx_ready stall on the ACK
    wq.delete();
    send_byte(8'h23);
    check("hold before cmd", 64'(soc_hold), 64'(0));
    check("busy after sop", 64'(busy), 64'(1));
    send_byte(8'h07);
    check("hold after cmd", 64'(soc_hold), 64'(1));
    for (int i = 2; i < vecs[0].nb; i++) send_byte(vecs[0].b[8*(vecs[0].nb-1-i) +: 8]);
    for (int n = 0; n < 20 && tx_valid !== 1'b1; n++) begin @(posedge clk); #1; end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_valid !== 1'b1 || tx_data !== 8'h06 || soc_hold !== 1'b1) bad++;
      @(posedge clk); #1;
    end
    check("stall stable cycles bad", 64'(bad), 64'(0));
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    check("after accept", {tx_valid, soc_hold, busy}, 3'b000);
    check("stall nwrites", 64'(wq.size()), 64'(2));

    // Inter-byte timeout inside the payload
    wq.delete();
    send_byte(8'h23); send_byte(8'h07); send_byte(8'h00); send_byte(8'h04); send_byte(8'haa);
    repeat (TO - 5) @(posedge clk);
    #1;
    check("before timeout", {tx_valid, busy}, 2'b01);
    expect_tx(8'h15, "timeout");
    check("timeout idle", {soc_hold, busy}, 2'b00);
    check("timeout nwrites", 64'(wq.size()), 64'(0));

    // Reset after the 6th byte of a write packet
    wq.delete();
    send_bytes(0, 6);
    resetn = 1'b0;
    #1;
    check("midreset outputs", {tx_valid, tx_data, progmem_wen, soc_hold, busy},
          {1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    check("midreset waddr/wdata", {progmem_waddr, progmem_wdata}, 64'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midreset no response", {tx_valid, busy}, 2'b00);
    check("midreset nwrites", 64'(wq.size()), 64'(0));
    run_vec(0);
    run_vec(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
